// File: rtl/adf_sweep_sched_pkg.sv
// rtl/adf_sweep_sched_pkg.sv - shared state encoding and defaults for the sweep scheduler
package adf_sweep_sched_pkg;

  localparam int SWP_FREQ_W = 24;

  typedef enum logic [2:0] {
    SWP_IDLE     = 3'd0,
    SWP_ARM      = 3'd1,
    SWP_WAIT_CFG = 3'd2,
    SWP_DWELL    = 3'd3,
    SWP_NEXT     = 3'd4,
    SWP_FINISH   = 3'd5
  } swp_state_e;

endpackage

// File: rtl/adf_sweep_sched_timer.sv
// rtl/adf_sweep_sched_timer.sv - loadable down-counter with terminal-count flag
module adf_sweep_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  // tc marks the last counted cycle; a zero count also reads as terminal
  assign tc_o = (count_q <= W'(1));

endmodule

// File: rtl/adf_sweep_sched.sv
// rtl/adf_sweep_sched.sv - frequency-sweep scheduler driving the dual-PLL configurator
module adf_sweep_sched
  import adf_sweep_sched_pkg::*;
#(
  parameter int FREQ_W      = SWP_FREQ_W,
  parameter int DWELL_W     = 20,
  parameter int IDX_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               ABORT,
  input  logic [FREQ_W-1:0]  F_START,
  input  logic [FREQ_W-1:0]  F_STOP,
  input  logic [FREQ_W-1:0]  F_STEP,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               CFG_DONE_FLAG,
  output logic               CFG_EN,
  output logic [FREQ_W-1:0]  FREQ,
  output logic               BUSY,
  output logic               DWELL_ACT,
  output logic [IDX_W-1:0]   POINT_IDX,
  output logic               SWEEP_DONE,
  output logic               TIMEOUT_ERR
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  swp_state_e         state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [FREQ_W-1:0]  stop_q, stop_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               to_err_q, to_err_d;
  logic               cfg_en_q, dwell_act_q, done_q, busy_q;
  logic               dwell_load, to_load, dwell_tc, to_tc;
  logic [FREQ_W:0]    sum;
  logic [DWELL_W-1:0] dwell_len;

  assign sum       = {1'b0, freq_q} + {1'b0, step_q};
  assign dwell_len = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

  adf_sweep_sched_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (dwell_load),
    .load_val_i (dwell_len),
    .en_i       (state_q == SWP_DWELL),
    .tc_o       (dwell_tc)
  );

  adf_sweep_sched_timer #(.W(TO_W)) u_timeout_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (to_load),
    .load_val_i (TO_W'(TIMEOUT_CYC)),
    .en_i       (state_q == SWP_WAIT_CFG),
    .tc_o       (to_tc)
  );

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    idx_d      = idx_q;
    to_err_d   = to_err_q;
    dwell_load = 1'b0;
    to_load    = 1'b0;
    case (state_q)
      SWP_IDLE: begin
        if (START && !ABORT) begin
          stop_d   = F_STOP;
          step_d   = F_STEP;
          dwell_d  = DWELL;
          freq_d   = F_START;
          idx_d    = '0;
          to_err_d = 1'b0;
          state_d  = SWP_ARM;
        end
      end
      SWP_ARM: begin
        to_load = 1'b1;
        state_d = SWP_WAIT_CFG;
      end
      SWP_WAIT_CFG: begin
        if (CFG_DONE_FLAG) begin
          dwell_load = 1'b1;
          state_d    = SWP_DWELL;
        end else if (to_tc) begin
          to_err_d = 1'b1;
          state_d  = SWP_FINISH;
        end
      end
      SWP_DWELL: begin
        if (dwell_tc) state_d = SWP_NEXT;
      end
      SWP_NEXT: begin
        // carry-out check keeps a sweep near full scale from wrapping to low frequencies
        if ((step_q == '0) || (sum > {1'b0, stop_q}) || sum[FREQ_W] || (&idx_q)) begin
          state_d = SWP_FINISH;
        end else begin
          freq_d  = sum[FREQ_W-1:0];
          idx_d   = idx_q + IDX_W'(1);
          state_d = SWP_ARM;
        end
      end
      SWP_FINISH: state_d = SWP_IDLE;
      default:    state_d = SWP_IDLE;
    endcase
    if (ABORT && (state_q != SWP_IDLE)) begin
      state_d    = SWP_IDLE;
      freq_d     = freq_q;
      idx_d      = idx_q;
      to_err_d   = to_err_q;
      dwell_load = 1'b0;
      to_load    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= SWP_IDLE;
      freq_q      <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      idx_q       <= '0;
      to_err_q    <= 1'b0;
      cfg_en_q    <= 1'b0;
      dwell_act_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      to_err_q    <= to_err_d;
      cfg_en_q    <= (state_d == SWP_ARM);
      dwell_act_q <= (state_d == SWP_DWELL);
      done_q      <= (state_d == SWP_FINISH);
      busy_q      <= (state_d != SWP_IDLE);
    end
  end

  assign CFG_EN      = cfg_en_q;
  assign FREQ        = freq_q;
  assign BUSY        = busy_q;
  assign DWELL_ACT   = dwell_act_q;
  assign POINT_IDX   = idx_q;
  assign SWEEP_DONE  = done_q;
  assign TIMEOUT_ERR = to_err_q;

endmodule

// File: tb/tb_adf_sweep_sched.sv
// tb/tb_adf_sweep_sched.sv - scoreboard bench for the frequency-sweep scheduler
module tb_adf_sweep_sched;

  localparam int TO_CYC = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [23:0] F_START = '0;
  logic [23:0] F_STOP = '0;
  logic [23:0] F_STEP = '0;
  logic [19:0] DWELL = '0;
  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        CFG_DONE_FLAG;
  logic        CFG_EN;
  logic [23:0] FREQ;
  logic        BUSY;
  logic        DWELL_ACT;
  logic [15:0] POINT_IDX;
  logic        SWEEP_DONE;
  logic        TIMEOUT_ERR;

  assign CFG_DONE_FLAG = model_done | spur_done;

  adf_sweep_sched #(
    .FREQ_W(24), .DWELL_W(20), .IDX_W(16), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .F_START(F_START), .F_STOP(F_STOP), .F_STEP(F_STEP), .DWELL(DWELL),
    .CFG_DONE_FLAG(CFG_DONE_FLAG), .CFG_EN(CFG_EN), .FREQ(FREQ), .BUSY(BUSY),
    .DWELL_ACT(DWELL_ACT), .POINT_IDX(POINT_IDX), .SWEEP_DONE(SWEEP_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [23:0] freq;
    logic [15:0] idx;
  } pt_t;

  pt_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cfg_cnt = 0;
  int   done_cnt = 0;
  int   cfg_cyc = 0;
  int   done_cyc = 0;
  int   to_rise_cyc = -1;
  int   dwell_end_cyc = 0;
  int   dwell_run = 0;
  int   exp_dwell = 0;
  bit   dwell_chk = 0;
  logic prev_dwell = 1'b0;
  logic prev_to = 1'b0;
  bit   model_en = 0;
  int   model_delay = 50;
  int   model_cnt = 0;

  // output monitor: pops expected points on each CFG_EN, measures dwell windows
  initial begin
    pt_t p;
    forever begin
      @(negedge CLK);
      cyc++;
      if (CFG_EN === 1'b1) begin
        cfg_cnt++;
        cfg_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cfg_en got=1 exp=0 freq=%0h", FREQ);
        end else begin
          p = exp_q.pop_front();
          if ({FREQ, POINT_IDX} !== {p.freq, p.idx}) begin
            failures++;
            $display("FAIL point freq=%0h idx=%0d exp freq=%0h idx=%0d", FREQ, POINT_IDX, p.freq, p.idx);
          end
        end
      end
      if (DWELL_ACT === 1'b1) begin
        dwell_run++;
      end else begin
        if (prev_dwell === 1'b1) begin
          dwell_end_cyc = cyc;
          if (dwell_chk) begin
            checks++;
            if (dwell_run !== exp_dwell) begin
              failures++;
              $display("FAIL dwell_len got=%0d exp=%0d", dwell_run, exp_dwell);
            end
          end
        end
        dwell_run = 0;
      end
      prev_dwell = DWELL_ACT;
      if (SWEEP_DONE === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (TIMEOUT_ERR === 1'b1 && prev_to !== 1'b1) to_rise_cyc = cyc;
      prev_to = TIMEOUT_ERR;
    end
  end

  // configurator model: one-cycle done pulse model_delay cycles after CFG_EN
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      model_done = 1'b0;
      if (CFG_EN === 1'b1 && model_en) begin
        model_cnt = model_delay;
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) model_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic build_points(input logic [23:0] fs, input logic [23:0] fe, input logic [23:0] st);
    logic [24:0] s;
    pt_t p;
    p.freq = fs;
    p.idx = '0;
    forever begin
      exp_q.push_back(p);
      s = {1'b0, p.freq} + {1'b0, st};
      if (st == 0 || s > {1'b0, fe} || s[24] || p.idx == 16'hFFFF) break;
      p.freq = s[23:0];
      p.idx = p.idx + 16'd1;
    end
  endtask

  task automatic start_sweep(input logic [23:0] fs, input logic [23:0] fe,
                             input logic [23:0] st, input logic [19:0] dw);
    F_START = fs;
    F_STOP = fe;
    F_STEP = st;
    DWELL = dw;
    build_points(fs, fe, st);
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if ({BUSY, CFG_EN} !== 2'b11) begin
      failures++;
      $display("FAIL start_latency busy_cfg_en=%b exp=11", {BUSY, CFG_EN});
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (BUSY === 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL idle_wait busy=%b exp=0 after %0d cycles", BUSY, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if ({CFG_EN, FREQ, BUSY, DWELL_ACT, POINT_IDX, SWEEP_DONE, TIMEOUT_ERR} !== '0) begin
      failures++;
      $display("FAIL reset_outputs cfg=%b freq=%0h busy=%b dw=%b idx=%0d done=%b to=%b exp=all0",
               CFG_EN, FREQ, BUSY, DWELL_ACT, POINT_IDX, SWEEP_DONE, TIMEOUT_ERR);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int c0 = cfg_cnt;
    int d0 = done_cnt;
    model_en = 1;
    model_delay = 50;
    exp_dwell = 10;
    dwell_chk = 1;
    start_sweep(24'd1000000, 24'd1002000, 24'd1000, 20'd10);
    F_STOP = 24'd5;
    F_STEP = 24'd1;
    DWELL = 20'd3;
    wait_idle(2000);
    checks++;
    if (cfg_cnt - c0 !== 3) begin
      failures++;
      $display("FAIL basic_cfg_count got=%0d exp=3", cfg_cnt - c0);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if ({TIMEOUT_ERR, FREQ} !== {1'b0, 24'd1002000}) begin
      failures++;
      $display("FAIL basic_final to=%b freq=%0d exp to=0 freq=1002000", TIMEOUT_ERR, FREQ);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_missing_points got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_single();
    int c0 = cfg_cnt;
    int d0 = done_cnt;
    exp_dwell = 1;
    start_sweep(24'd500000, 24'd500000, 24'd0, 20'd0);
    wait_idle(500);
    checks++;
    if ({cfg_cnt - c0, done_cnt - d0} !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL single_counts cfg=%0d done=%0d exp=1 1", cfg_cnt - c0, done_cnt - d0);
    end
    checks++;
    if (done_cyc !== dwell_end_cyc + 1) begin
      failures++;
      $display("FAIL single_done_timing got=%0d exp=%0d", done_cyc, dwell_end_cyc + 1);
    end
    exp_dwell = 2;
    c0 = cfg_cnt;
    start_sweep(24'd2000, 24'd1000, 24'd10, 20'd2);
    wait_idle(500);
    checks++;
    if ({cfg_cnt - c0, exp_q.size()} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL start_above_stop cfg=%0d left=%0d exp=1 0", cfg_cnt - c0, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    model_en = 0;
    dwell_chk = 0;
    to_rise_cyc = -1;
    start_sweep(24'd300000, 24'd300100, 24'd100, 20'd5);
    wait_idle(500);
    checks++;
    if (TIMEOUT_ERR !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err got=%b exp=1", TIMEOUT_ERR);
    end
    checks++;
    if (to_rise_cyc - cfg_cyc !== TO_CYC + 1) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", to_rise_cyc - cfg_cyc, TO_CYC + 1);
    end
    checks++;
    if ({done_cnt - d0, done_cyc} !== {32'd1, to_rise_cyc}) begin
      failures++;
      $display("FAIL timeout_done cnt=%0d cyc=%0d exp=1 %0d", done_cnt - d0, done_cyc, to_rise_cyc);
    end
    checks++;
    if (exp_q.size() != 1) begin
      failures++;
      $display("FAIL timeout_points_left got=%0d exp=1", exp_q.size());
    end
    exp_q.delete();
    repeat (5) tick();
    checks++;
    if (TIMEOUT_ERR !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got=%b exp=1", TIMEOUT_ERR);
    end
    model_en = 1;
    model_delay = 8;
    exp_dwell = 5;
    dwell_chk = 1;
    start_sweep(24'd300000, 24'd300000, 24'd0, 20'd5);
    checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", TIMEOUT_ERR);
    end
    wait_idle(500);
  endtask

  task automatic test_abort();
    int n = 0;
    int c0;
    int d0 = done_cnt;
    model_en = 1;
    model_delay = 20;
    exp_dwell = 20;
    dwell_chk = 1;
    start_sweep(24'd1000, 24'd3000, 24'd1000, 20'd20);
    while (!(DWELL_ACT === 1'b1 && POINT_IDX === 16'd1) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL abort_reach_point1 got=timeout exp=dwell_of_point1");
    end
    repeat (3) tick();
    dwell_chk = 0;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if ({BUSY, DWELL_ACT, SWEEP_DONE, TIMEOUT_ERR} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_state busy_dw_done_to=%b exp=0000", {BUSY, DWELL_ACT, SWEEP_DONE, TIMEOUT_ERR});
    end
    checks++;
    if (exp_q.size() != 1) begin
      failures++;
      $display("FAIL abort_points_left got=%0d exp=1", exp_q.size());
    end
    exp_q.delete();
    c0 = cfg_cnt;
    repeat (100) tick();
    checks++;
    if ({cfg_cnt - c0, done_cnt - d0} !== {32'd0, 32'd0}) begin
      failures++;
      $display("FAIL abort_quiet cfg=%0d done=%0d exp=0 0", cfg_cnt - c0, done_cnt - d0);
    end
  endtask

  task automatic test_carry();
    int c0 = cfg_cnt;
    int d0 = done_cnt;
    model_delay = 10;
    exp_dwell = 2;
    dwell_chk = 1;
    start_sweep(24'hFFFF00, 24'hFFFFFF, 24'h80, 20'd2);
    wait_idle(500);
    checks++;
    if ({cfg_cnt - c0, done_cnt - d0} !== {32'd2, 32'd1}) begin
      failures++;
      $display("FAIL carry_counts cfg=%0d done=%0d exp=2 1", cfg_cnt - c0, done_cnt - d0);
    end
    checks++;
    if (FREQ !== 24'hFFFF80) begin
      failures++;
      $display("FAIL carry_final_freq got=%0h exp=ffff80", FREQ);
    end
  endtask

  task automatic test_reset_mid();
    int c0 = cfg_cnt;
    int d0 = done_cnt;
    model_delay = 50;
    dwell_chk = 0;
    F_START = 24'd1000000;
    F_STOP = 24'd1002000;
    F_STEP = 24'd1000;
    DWELL = 20'd10;
    build_points(24'd1000000, 24'd1002000, 24'd1000);
    START = 1'b1;
    repeat (20) tick();
    checks++;
    if ({cfg_cnt - c0, BUSY, POINT_IDX, FREQ} !== {32'd1, 1'b1, 16'd0, 24'd1000000}) begin
      failures++;
      $display("FAIL start_while_busy cfg=%0d busy=%b idx=%0d freq=%0d exp=1 1 0 1000000",
               cfg_cnt - c0, BUSY, POINT_IDX, FREQ);
    end
    RST = 1'b0;
    tick();
    START = 1'b0;
    tick();
    checks++;
    if ({CFG_EN, FREQ, BUSY, DWELL_ACT, POINT_IDX, SWEEP_DONE, TIMEOUT_ERR} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs cfg=%b freq=%0h busy=%b dw=%b idx=%0d done=%b to=%b exp=all0",
               CFG_EN, FREQ, BUSY, DWELL_ACT, POINT_IDX, SWEEP_DONE, TIMEOUT_ERR);
    end
    RST = 1'b1;
    exp_q.delete();
    model_en = 0;
    c0 = cfg_cnt;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (5) tick();
    checks++;
    if ({BUSY, DWELL_ACT, cfg_cnt - c0, done_cnt - d0} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL spurious_done busy=%b dw=%b cfg=%0d done=%0d exp=0 0 0 0",
               BUSY, DWELL_ACT, cfg_cnt - c0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_timeout();
    test_abort();
    test_carry();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
